im_fetch_ctrl: RTL

//   Instruction-fetch sequencer for the rv32i core. Owns the PC, drives the word

---
 rtl/im_fetch_ctrl.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/im_fetch_ctrl.sv
// im_fetch_ctrl
//   Instruction-fetch sequencer for the rv32i core. Holds the byte PC, presents
//   the word address to a combinational instruction memory, and hands each
//   fetched instruction plus its PC to decode over a valid/ready handshake.
//   Fetching starts on a start pulse. Decode backpressure stalls the fetch.
//   Branch/jump redirects reload the PC. An EBREAK drains and then halts.
//
// Ports
//   clk            : system clock, rising edge
//   rst            : synchronous active-high reset, overrides all other inputs
//   start          : pulse, leave IDLE and fetch from the current pc
//   redirect_valid : load redirect_pc (low 2 bits dropped)
//   redirect_pc    : new byte PC
//   addressIM      : IM word address, pc[ADDR_W+1:2]
//   inst           : IM read data for addressIM (same cycle)
//   out_valid      : out_inst/out_pc hold an instruction for decode
//   out_ready      : decode accepts the instruction this cycle
//   out_inst       : registered instruction
//   out_pc         : byte PC of out_inst
//   halted         : high while in HALT
//   fetch_count    : completed out_valid&&out_ready handshakes (wraps)
module im_fetch_ctrl #(
  parameter int unsigned ADDR_W   = 5,
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic [ADDR_W-1:0] addressIM,
  input  logic [31:0]       inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [31:0]       out_pc,
  output logic              halted,
  output logic [CNT_W-1:0]  fetch_count
);

  localparam logic [31:0] EBREAK = 32'h00100073;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_HALT
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_inst_q, out_inst_d;
  logic [31:0]       out_pc_q, out_pc_d;
  logic              halted_q, halted_d;
  logic [CNT_W-1:0]  fetch_count_q, fetch_count_d;

  logic              handshake;
  logic              slot_free;
  logic [31:0]       redirect_aligned;
  logic              unused_redirect_lsbs;

  assign handshake            = out_valid_q && out_ready;
  assign slot_free            = !out_valid_q || out_ready;
  assign redirect_aligned     = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // Word address wraps naturally by taking only ADDR_W bits of the PC.
  assign addressIM   = pc_q[ADDR_W+1:2];
  assign out_valid   = out_valid_q;
  assign out_inst    = out_inst_q;
  assign out_pc      = out_pc_q;
  assign halted      = halted_q;
  assign fetch_count = fetch_count_q;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    out_valid_d   = out_valid_q;
    out_inst_d    = out_inst_q;
    out_pc_d      = out_pc_q;
    halted_d      = halted_q;
    // A handshake is counted even when a redirect lands in the same cycle.
    fetch_count_d = fetch_count_q + CNT_W'(handshake);

    case (state_q)
      S_IDLE: begin
        if (redirect_valid) begin
          pc_d = redirect_aligned;
        end
        if (start) begin
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        if (redirect_valid) begin
          pc_d        = redirect_aligned;
          out_valid_d = 1'b0;
        end else if (slot_free) begin
          out_inst_d  = inst;
          out_pc_d    = pc_q;
          out_valid_d = 1'b1;
          pc_d        = pc_q + 32'd4;
          if (inst == EBREAK) begin
            state_d = S_DRAIN;
          end
        end
      end

      S_DRAIN: begin
        if (redirect_valid) begin
          pc_d        = redirect_aligned;
          out_valid_d = 1'b0;
          state_d     = S_RUN;
        end else if (slot_free) begin
          // The EBREAK has been accepted (or was never pending): stop.
          out_valid_d = 1'b0;
          state_d     = S_HALT;
          halted_d    = 1'b1;
        end
      end

      S_HALT: begin
        out_valid_d = 1'b0;
        if (redirect_valid) begin
          pc_d     = redirect_aligned;
          state_d  = S_RUN;
          halted_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      out_valid_q   <= 1'b0;
      out_inst_q    <= '0;
      out_pc_q      <= '0;
      halted_q      <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      out_valid_q   <= out_valid_d;
      out_inst_q    <= out_inst_d;
      out_pc_q      <= out_pc_d;
      halted_q      <= halted_d;
      fetch_count_q <= fetch_count_d;
    end
  end

endmodule
